// File: rtl/tpu_seq.sv
// tpu_seq: sequences one 8x8 matmul job on a tpuv1 array.
// Phases: clear C, stream in A and B rows, run the systolic steps, then read back C.
// Optional build macro TPU_SEQ_PERF_EN adds the perf_cycles busy-cycle counter port.
// Row packing on every 128-bit bus: column c occupies bits [32*(c%4) +: 32],
// with the high bus carrying columns 7:4 and the low bus carrying columns 3:0.
// The tpu_* command outputs are decoded from the current state and the operand
// handshake. They are not registered, so a write is issued in its handshake cycle.
module tpu_seq #(
    localparam int unsigned ROW_W  = 128,
    localparam int unsigned OP_W   = 3,
    localparam int unsigned IDX_W  = 4,
    localparam int unsigned R_W    = 3,
    localparam int unsigned STEP_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ROW_W-1:0] in_high,
    input  logic [ROW_W-1:0] in_low,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] out_high,
    output logic [ROW_W-1:0] out_low,
    output logic [OP_W-1:0]  tpu_opcode,
    output logic [IDX_W-1:0] tpu_idx,
    output logic             tpu_hl,
    output logic [ROW_W-1:0] tpu_v_high,
    output logic [ROW_W-1:0] tpu_v_low,
    input  logic [ROW_W-1:0] tpu_data_out
`ifdef TPU_SEQ_PERF_EN
    ,
    output logic [31:0]      perf_cycles
`endif
);

    localparam logic [OP_W-1:0] OP_NOP   = 3'd0;
    localparam logic [OP_W-1:0] OP_WR_A  = 3'd1;
    localparam logic [OP_W-1:0] OP_WR_B  = 3'd2;
    localparam logic [OP_W-1:0] OP_WR_C  = 3'd3;
    localparam logic [OP_W-1:0] OP_RD_C  = 3'd5;
    localparam logic [OP_W-1:0] OP_STEP  = 3'd6;

    localparam logic [R_W-1:0]    LAST_ROW  = 3'd7;
    localparam logic [STEP_W-1:0] LAST_STEP = 5'd21;

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        LOAD_A,
        LOAD_B,
        STEP,
        RD_H,
        RD_L,
        RD_CAP,
        OUT
    } state_t;

    state_t              state_q, state_d;
    logic [R_W-1:0]      row_q, row_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [ROW_W-1:0]    out_high_d, out_low_d;
    logic                done_d;
    logic                in_hs;
    logic                out_hs;

    // Next-state logic, captured read data and the tpu command for this cycle
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        step_d     = step_q;
        out_high_d = out_high;
        out_low_d  = out_low;
        done_d     = 1'b0;
        tpu_opcode = OP_NOP;
        tpu_idx    = '0;
        tpu_hl     = 1'b0;
        tpu_v_high = '0;
        tpu_v_low  = '0;
        in_hs      = in_valid && in_ready;
        out_hs     = out_valid && out_ready;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    row_d   = '0;
                end
            end
            CLEAR: begin
                tpu_opcode = OP_WR_C;
                tpu_idx    = IDX_W'(row_q);
                row_d      = row_q + 3'd1;
                if (row_q == LAST_ROW) begin
                    state_d = LOAD_A;
                end
            end
            LOAD_A, LOAD_B: begin
                if (in_hs) begin
                    tpu_opcode = (state_q == LOAD_A) ? OP_WR_A : OP_WR_B;
                    tpu_idx    = IDX_W'(row_q);
                    tpu_v_high = in_high;
                    tpu_v_low  = in_low;
                    row_d      = row_q + 3'd1;
                    if (row_q == LAST_ROW) begin
                        state_d = (state_q == LOAD_A) ? LOAD_B : STEP;
                        step_d  = '0;
                    end
                end
            end
            STEP: begin
                tpu_opcode = OP_STEP;
                step_d     = step_q + 5'd1;
                if (step_q == LAST_STEP) begin
                    state_d = RD_H;
                    step_d  = '0;
                    row_d   = '0;
                end
            end
            RD_H: begin
                tpu_opcode = OP_RD_C;
                tpu_hl     = 1'b1;
                tpu_idx    = IDX_W'(row_q);
                state_d    = RD_L;
            end
            RD_L: begin
                // Data returned here belongs to the high-half read issued in RD_H
                tpu_opcode = OP_RD_C;
                tpu_idx    = IDX_W'(row_q);
                out_high_d = tpu_data_out;
                state_d    = RD_CAP;
            end
            RD_CAP: begin
                out_low_d = tpu_data_out;
                state_d   = OUT;
            end
            OUT: begin
                if (out_hs) begin
                    if (row_q == LAST_ROW) begin
                        state_d = IDLE;
                        row_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RD_H;
                        row_d   = row_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Hold the tpu idle while reset is applied so an aborted job issues nothing
        if (rst) begin
            tpu_opcode = OP_NOP;
            tpu_idx    = '0;
            tpu_hl     = 1'b0;
            tpu_v_high = '0;
            tpu_v_low  = '0;
        end
    end

    // State register; status outputs are registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            step_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_high  <= '0;
            out_low   <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            step_q    <= step_d;
            busy      <= (state_d != IDLE);
            done      <= done_d;
            in_ready  <= (state_d == LOAD_A) || (state_d == LOAD_B);
            out_valid <= (state_d == OUT);
            out_high  <= out_high_d;
            out_low   <= out_low_d;
        end
    end

`ifdef TPU_SEQ_PERF_EN
    // Busy-cycle counter for the current job; it holds its value once the job is done
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if ((state_q == IDLE) && start) begin
            perf_cycles <= '0;
        end else if (busy) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tpu_seq.sv
// tb_tpu_seq: randomized jobs against a behavioural tpuv1 model and a golden A*B scoreboard.
module tb_tpu_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] in_high = '0;
    logic [127:0] in_low = '0;
    logic [127:0] tpu_data_out = '0;
    logic         busy, done, in_ready, out_valid, tpu_hl;
    logic [127:0] out_high, out_low, tpu_v_high, tpu_v_low;
    logic [2:0]   tpu_opcode;
    logic [3:0]   tpu_idx;
`ifdef TPU_SEQ_PERF_EN
    logic [31:0]  perf_cycles;
`endif

    always #5 clk = ~clk;

    tpu_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_high      (in_high),
        .in_low       (in_low),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_high     (out_high),
        .out_low      (out_low),
        .tpu_opcode   (tpu_opcode),
        .tpu_idx      (tpu_idx),
        .tpu_hl       (tpu_hl),
        .tpu_v_high   (tpu_v_high),
        .tpu_v_low    (tpu_v_low),
        .tpu_data_out (tpu_data_out)
`ifdef TPU_SEQ_PERF_EN
        ,
        .perf_cycles  (perf_cycles)
`endif
    );

    int tests = 0;
    int fails = 0;

    int unsigned gA[8][8];
    int unsigned gB[8][8];
    int unsigned gC[8][8];
    int unsigned tA[8][8];
    int unsigned tB[8][8];
    int unsigned tC[8][8];
    int          tsteps = 0;

    // Scoreboard state, written only by the monitor
    bit mon_en = 1'b0;
    bit exp_busy = 1'b0;
    bit exp_done = 1'b0;
    bit job_fin = 1'b0;
    bit unstalled = 1'b0;
    bit prev_ov = 1'b0;
    bit prev_or = 1'b0;
    logic [255:0] prev_out = '0;
    int feed_idx = 0;
    int rd_cnt = 0;
    int out_cnt = 0;
    int steps = 0;
    int busy_cnt = 0;
    int job_id = -1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Row r of A (0), B (1) or golden C (2), column c at bits [32*c +: 32]
    function automatic logic [255:0] mrow(input int which, input int r);
        logic [255:0] v;
        v = '0;
        for (int c = 0; c < 8; c++) begin
            if (which == 0)      v[32*c +: 32] = gA[r][c];
            else if (which == 1) v[32*c +: 32] = gB[r][c];
            else                 v[32*c +: 32] = gC[r][c];
        end
        return v;
    endfunction

    function automatic logic [255:0] feed_row(input int f);
        if (f < 8)  return mrow(0, f);
        if (f < 16) return mrow(1, f - 8);
        return '0;
    endfunction

    // Behavioural tpuv1: C gets A*B once 22 systolic steps have been applied
    always @(posedge clk) begin
        logic [255:0] v;
        logic [255:0] crow;
        int unsigned  acc;
        v = {tpu_v_high, tpu_v_low};
        case (tpu_opcode)
            3'd1: for (int c = 0; c < 8; c++) tA[tpu_idx[2:0]][c] = v[32*c +: 32];
            3'd2: for (int c = 0; c < 8; c++) tB[tpu_idx[2:0]][c] = v[32*c +: 32];
            3'd3: begin
                for (int c = 0; c < 8; c++) tC[tpu_idx[2:0]][c] = v[32*c +: 32];
                tsteps = 0;
            end
            3'd6: begin
                tsteps++;
                if (tsteps == 22) begin
                    for (int i = 0; i < 8; i++) begin
                        for (int j = 0; j < 8; j++) begin
                            acc = tC[i][j];
                            for (int k = 0; k < 8; k++) acc += tA[i][k] * tB[k][j];
                            tC[i][j] = acc;
                        end
                    end
                end
            end
            3'd5: begin
                crow = '0;
                for (int c = 0; c < 8; c++) crow[32*c +: 32] = tC[tpu_idx[2:0]][c];
                tpu_data_out <= tpu_hl ? crow[255:128] : crow[127:0];
            end
            default: ;
        endcase
    end

    // Per-cycle compare process, sampled on the falling edge
    always @(negedge clk) begin
        bit hs_in, hs_out, fin, op_wr;
        logic [2:0] exp_op;
        if (mon_en) begin
            hs_in  = in_valid && in_ready && !rst;
            hs_out = out_valid && out_ready && !rst;
            fin    = hs_out && (out_cnt == 7);
            op_wr  = (tpu_opcode == 3'd1) || (tpu_opcode == 3'd2);

            check("busy", 256'(busy), 256'(exp_busy));
            check("done", 256'(done), 256'(exp_done));
            if (done) begin
                if (unstalled) check("latency", 256'(busy_cnt), 256'(78));
                check("rows_at_done", 256'(out_cnt), 256'(8));
`ifdef TPU_SEQ_PERF_EN
                check("perf_cycles", 256'(perf_cycles), 256'(busy_cnt));
`endif
                job_fin = 1'b1;
            end
            if (!exp_busy)
                check("idle_outputs", 256'({in_ready, out_valid, tpu_opcode}), 256'(0));
            if ((tpu_opcode == 3'd0) || (tpu_opcode == 3'd6))
                check("idx_hl_zero", 256'({tpu_idx, tpu_hl}), 256'(0));

            if (!rst && (hs_in || op_wr)) begin
                exp_op = (feed_idx < 8) ? 3'd1 : (feed_idx < 16) ? 3'd2 : 3'd7;
                check("write_cmd", 256'({hs_in, tpu_opcode, tpu_idx}),
                      256'({1'b1, exp_op, 4'(feed_idx % 8)}));
                check("write_data", {tpu_v_high, tpu_v_low}, feed_row(feed_idx));
            end
            if (hs_in) feed_idx++;
            if (tpu_opcode == 3'd6) steps++;
            if (tpu_opcode == 3'd5) begin
                if (rd_cnt == 0) check("step_count", 256'(steps), 256'(22));
                check("read_cmd", 256'({out_valid, tpu_hl, tpu_idx}),
                      256'({1'b0, (rd_cnt % 2) == 0, 4'(rd_cnt / 2)}));
                rd_cnt++;
            end

            if (out_valid && prev_ov && !prev_or)
                check("out_stable", {out_high, out_low}, prev_out);
            if (hs_out) begin
                check("result_row", {out_high, out_low}, mrow(2, out_cnt));
                check("reads_before_row", 256'(rd_cnt), 256'(2 * (out_cnt + 1)));
                if (job_id == 0 && out_cnt == 3)
                    check("pinned_c35", 256'(out_high[63:32]), 256'(16));
                out_cnt++;
            end
            if (busy) busy_cnt++;

            prev_ov  = out_valid;
            prev_or  = out_ready;
            prev_out = {out_high, out_low};
            exp_done = fin;
            if (rst) begin
                exp_busy = 1'b0;
                exp_done = 1'b0;
                feed_idx = 0;
                rd_cnt   = 0;
                out_cnt  = 0;
                steps    = 0;
            end else if (!exp_busy && start) begin
                exp_busy = 1'b1;
                job_fin  = 1'b0;
                feed_idx = 0;
                rd_cnt   = 0;
                out_cnt  = 0;
                steps    = 0;
                busy_cnt = 0;
                job_id++;
            end else if (fin) begin
                exp_busy = 1'b0;
            end
        end
    end

    // mode: 0 no stalls, 1 in_valid every other cycle, 2 row-3 output stall,
    // 3 start pulse during STEP, 4 reset at 5th STEP cycle, 5 random stalls
    task automatic run_job(input int mode, input bit det);
        int cyc, hold, stp;
        bit held, alt;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                gA[i][j] = det ? ((i == j) ? 32'd2 : 32'd0) : $urandom;
                gB[i][j] = det ? 32'(i + j) : $urandom;
            end
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                gC[i][j] = 0;
                for (int k = 0; k < 8; k++) gC[i][j] += gA[i][k] * gB[k][j];
            end
        end
        if (det) begin
            check("golden_c35", 256'(gC[3][5]), 256'(16));
            check("golden_c70", 256'(gC[7][0]), 256'(14));
        end
        unstalled = (mode == 0) || (mode == 3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; hold = 0; stp = 0; held = 1'b0; alt = 1'b0;
        while (!job_fin && cyc < 3000) begin
            case (mode)
                1:       begin in_valid = alt; alt = !alt; end
                5:       in_valid = 1'($urandom % 2);
                default: in_valid = 1'b1;
            endcase
            if (feed_idx < 16) {in_high, in_low} = feed_row(feed_idx);
            else               {in_high, in_low} = {$urandom, $urandom, $urandom, $urandom,
                                                    $urandom, $urandom, $urandom, $urandom};
            if (mode == 5) begin
                out_ready = ($urandom % 3) != 0;
            end else if (mode == 2) begin
                if (!held && out_valid && out_cnt == 3) begin
                    hold = 10;
                    held = 1'b1;
                end
                out_ready = (hold == 0);
                if (hold > 0) hold--;
            end else begin
                out_ready = 1'b1;
            end
            if (tpu_opcode == 3'd6) stp++;
            start = (mode == 3) && (tpu_opcode == 3'd6) && (stp == 3);
            if (mode == 4 && tpu_opcode == 3'd6 && stp == 5) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (mode != 4) check("job_timeout", 256'(job_fin), 256'(1));
        repeat (4) begin
            in_valid = 1'($urandom % 2);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        check("rst_status", 256'({busy, done, in_ready, out_valid}), 256'(0));
        check("rst_cmd", 256'({tpu_opcode, tpu_idx, tpu_hl}), 256'(0));
        check("rst_vdata", {tpu_v_high, tpu_v_low}, 256'(0));
        check("rst_out", {out_high, out_low}, 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_job(0, 1'b1);
        run_job(0, 1'b0);
        run_job(1, 1'b0);
        run_job(2, 1'b0);
        run_job(3, 1'b0);
        run_job(4, 1'b0);
        run_job(0, 1'b0);
        for (int n = 0; n < 3; n++) run_job(5, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
